// File: rtl/fft_frame_feeder.sv
// Captures one frame of N real ADC samples into block RAM, then streams it to an FFT sink with sop/eop/valid framing.
// Optional mean removal of each frame is built when FFT_FEEDER_DC_REMOVE_EN is defined.
module fft_frame_feeder #(
    parameter int N  = 1024,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] adc_data,
    input  logic          adc_valid,
    input  logic          sink_ready,
    output logic          sink_valid,
    output logic          sink_sop,
    output logic          sink_eop,
    output logic [DW-1:0] sink_real,
    output logic [DW-1:0] sink_imag,
    output logic          busy,
    output logic          frame_done
);
    localparam int AW = $clog2(N);

    typedef enum logic [1:0] {IDLE, FILL, SEND} state_t;

    state_t          state_reg;
    logic [AW-1:0]   wr_cnt_reg;
    logic [AW:0]     rd_addr_reg;
    logic [AW-1:0]   out_cnt_reg;
    logic            pf_valid_reg;
    logic [DW-1:0]   rd_data_reg;
    logic [DW-1:0]   ram [N];

    logic            valid_reg;
    logic            sop_reg;
    logic            eop_reg;
    logic [DW-1:0]   real_reg;
    logic            busy_reg;
    logic            done_reg;

    logic            wr_en;
    logic            xfer;
    logic            load_out;
    logic            rd_en;
    logic            last_xfer;
    logic            wr_last;
    logic [DW-1:0]   beat_val;

    assign wr_en     = (state_reg == FILL) && adc_valid;
    assign wr_last   = wr_en && (wr_cnt_reg == AW'(N - 1));
    assign xfer      = valid_reg && sink_ready;
    // The prefetch register always holds the beat after the one on the output,
    // so a transfer can refill the output on the same edge without a bubble.
    assign load_out  = pf_valid_reg && (!valid_reg || xfer);
    assign rd_en     = (state_reg == SEND) && (rd_addr_reg != (AW + 1)'(N))
                       && (!pf_valid_reg || load_out);
    assign last_xfer = xfer && eop_reg;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            ram[wr_cnt_reg] <= adc_data;
        end
        if (rd_en) begin
            rd_data_reg <= ram[rd_addr_reg[AW-1:0]];
        end
    end

`ifdef FFT_FEEDER_DC_REMOVE_EN
    localparam int XW = DW + AW + 1;
    localparam logic signed [XW-1:0] MAXV = XW'(2 ** (DW - 1) - 1);
    localparam logic signed [XW-1:0] MINV = ~MAXV;

    logic signed [DW+AW-1:0] acc_reg;
    logic signed [DW+AW-1:0] acc_next;
    logic signed [DW+AW-1:0] mean_reg;
    logic signed [XW-1:0]    diff;

    assign acc_next = acc_reg + {{AW{adc_data[DW-1]}}, adc_data};

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_reg  <= '0;
            mean_reg <= '0;
        end else if ((state_reg == IDLE) && start) begin
            acc_reg <= '0;
        end else if (wr_en) begin
            acc_reg <= acc_next;
            if (wr_last) begin
                mean_reg <= acc_next >>> AW;
            end
        end
    end

    always_comb begin
        diff = {{(AW + 1){rd_data_reg[DW-1]}}, rd_data_reg} - {mean_reg[DW+AW-1], mean_reg};
        if (diff > MAXV) begin
            beat_val = {1'b0, {(DW - 1){1'b1}}};
        end else if (diff < MINV) begin
            beat_val = {1'b1, {(DW - 1){1'b0}}};
        end else begin
            beat_val = diff[DW-1:0];
        end
    end
`else
    assign beat_val = rd_data_reg;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            wr_cnt_reg   <= '0;
            rd_addr_reg  <= '0;
            out_cnt_reg  <= '0;
            pf_valid_reg <= 1'b0;
            valid_reg    <= 1'b0;
            sop_reg      <= 1'b0;
            eop_reg      <= 1'b0;
            real_reg     <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    wr_cnt_reg   <= '0;
                    rd_addr_reg  <= '0;
                    out_cnt_reg  <= '0;
                    pf_valid_reg <= 1'b0;
                    if (start) begin
                        state_reg <= FILL;
                        busy_reg  <= 1'b1;
                    end
                end
                FILL: begin
                    if (wr_en) begin
                        wr_cnt_reg <= wr_cnt_reg + 1'b1;
                    end
                    if (wr_last) begin
                        state_reg <= SEND;
                    end
                end
                SEND: begin
                    if (rd_en) begin
                        rd_addr_reg  <= rd_addr_reg + 1'b1;
                        pf_valid_reg <= 1'b1;
                    end else if (load_out) begin
                        pf_valid_reg <= 1'b0;
                    end
                    if (load_out) begin
                        valid_reg   <= 1'b1;
                        real_reg    <= beat_val;
                        sop_reg     <= (out_cnt_reg == '0);
                        eop_reg     <= (out_cnt_reg == AW'(N - 1));
                        out_cnt_reg <= out_cnt_reg + 1'b1;
                    end else if (last_xfer) begin
                        valid_reg <= 1'b0;
                        sop_reg   <= 1'b0;
                        eop_reg   <= 1'b0;
                        real_reg  <= '0;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign sink_valid = valid_reg;
    assign sink_sop   = sop_reg;
    assign sink_eop   = eop_reg;
    assign sink_real  = real_reg;
    assign sink_imag  = '0;
    assign busy       = busy_reg;
    assign frame_done = done_reg;
endmodule

// File: tb/tb_fft_frame_feeder.sv
// Directed bench for fft_frame_feeder with N=8, DW=16; one task per scenario, expectations computed by hand.
module tb_fft_frame_feeder;
    localparam int N  = 8;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [DW-1:0] adc_data;
    logic          adc_valid;
    logic          sink_ready;
    logic          sink_valid;
    logic          sink_sop;
    logic          sink_eop;
    logic [DW-1:0] sink_real;
    logic [DW-1:0] sink_imag;
    logic          busy;
    logic          frame_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fft_frame_feeder #(.N(N), .DW(DW)) dut (
        .clk(clk), .rst(rst), .start(start), .adc_data(adc_data), .adc_valid(adc_valid),
        .sink_ready(sink_ready), .sink_valid(sink_valid), .sink_sop(sink_sop), .sink_eop(sink_eop),
        .sink_real(sink_real), .sink_imag(sink_imag), .busy(busy), .frame_done(frame_done)
    );

    // Expected output of a stored sample given the frame sum (mean removal when built in).
    function automatic int exp_beat(int s, int sum);
        int d;
        d = s;
`ifdef FFT_FEEDER_DC_REMOVE_EN
        d = s - (sum >>> 3);
        if (d > 32767) d = 32767;
        if (d < -32768) d = -32768;
`endif
        if (sum == 0) d = d + 0;
        return d;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_pulse();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic fill_consecutive(input int base);
        for (int i = 0; i < N; i++) begin
            adc_valid = 1'b1;
            adc_data  = DW'(base + i);
            tick();
        end
        adc_valid = 1'b0;
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int w = 0; w < 10; w++) begin
            if (sink_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int c = 0; c < 6; c++) begin
            start      = c[0];
            adc_valid  = ~c[0];
            adc_data   = DW'(c * 7 + 1);
            sink_ready = 1'b1;
            tick();
            checks++;
            if ({sink_valid, sink_sop, sink_eop, sink_real, sink_imag, busy, frame_done} !== '0) begin
                errors++;
                $display("FAIL reset_hold cycle %0d: got v=%b sop=%b eop=%b real=%0h imag=%0h busy=%b done=%b, want all 0",
                         c, sink_valid, sink_sop, sink_eop, sink_real, sink_imag, busy, frame_done);
            end
        end
        rst = 1'b0; start = 1'b0; adc_valid = 1'b0;
        tick();
        checks++;
        if ({busy, sink_valid} !== 2'b00) begin
            errors++;
            $display("FAIL reset_release: got busy=%b valid=%b, want 0 0", busy, sink_valid);
        end
    endtask

    task automatic test_basic();
        int got;
        sink_ready = 1'b1;
        start_pulse();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_busy_rise: got %b, want 1", busy);
        end
        fill_consecutive(1);
        checks++;
        if (sink_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_valid_edge0: got %b, want 0", sink_valid);
        end
        tick();
        checks++;
        if (sink_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_valid_edge1: got %b, want 0", sink_valid);
        end
        tick();
        checks++;
        if (sink_valid !== 1'b1) begin
            errors++;
            $display("FAIL basic_valid_edge2: got %b, want 1", sink_valid);
        end
        for (int b = 0; b < N; b++) begin
            got = int'($signed(sink_real));
            checks++;
            if (sink_valid !== 1'b1 || got != exp_beat(b + 1, 36) || sink_sop !== (b == 0)
                || sink_eop !== (b == N - 1) || sink_imag !== '0) begin
                errors++;
                $display("FAIL basic_beat%0d: got v=%b real=%0d sop=%b eop=%b imag=%0h, want v=1 real=%0d sop=%b eop=%b imag=0",
                         b, sink_valid, got, sink_sop, sink_eop, sink_imag, exp_beat(b + 1, 36), b == 0, b == N - 1);
            end
            tick();
        end
        checks++;
        if ({frame_done, busy, sink_valid} !== 3'b100) begin
            errors++;
            $display("FAIL basic_done: got done=%b busy=%b valid=%b, want 1 0 0", frame_done, busy, sink_valid);
        end
        tick();
        checks++;
        if (frame_done !== 1'b0) begin
            errors++;
            $display("FAIL basic_done_pulse: got %b, want 0", frame_done);
        end
    endtask

    task automatic test_backpressure();
        logic [5:0] pat;
        bit ok;
        bit r;
        int k;
        int c;
        int got;
        pat = 6'b101001;
        sink_ready = 1'b0;
        start_pulse();
        fill_consecutive(101);
        wait_valid(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL bp_wait_valid: got valid=%b, want 1 within 10 cycles", sink_valid);
            return;
        end
        k = 0;
        c = 0;
        while (k < N && c < 60) begin
            got = int'($signed(sink_real));
            checks++;
            if (sink_valid !== 1'b1 || got != exp_beat(101 + k, 836) || sink_sop !== (k == 0)
                || sink_eop !== (k == N - 1)) begin
                errors++;
                $display("FAIL bp_beat%0d cycle %0d: got v=%b real=%0d sop=%b eop=%b, want v=1 real=%0d sop=%b eop=%b",
                         k, c, sink_valid, got, sink_sop, sink_eop, exp_beat(101 + k, 836), k == 0, k == N - 1);
            end
            r = pat[c % 6];
            sink_ready = r;
            tick();
            if (r) k++;
            c++;
        end
        checks++;
        if (k != N || frame_done !== 1'b1) begin
            errors++;
            $display("FAIL bp_complete: got beats=%0d done=%b, want %0d 1", k, frame_done, N);
        end
        sink_ready = 1'b1;
        tick();
    endtask

    task automatic test_gaps_drops();
        bit ok;
        int got;
        sink_ready = 1'b1;
        start_pulse();
        for (int i = 0; i < N; i++) begin
            adc_valid = 1'b1;
            adc_data  = DW'(10 * (i + 1));
            tick();
            if (i < N - 1) begin
                adc_valid = 1'b0;
                adc_data  = 16'h0bad;
                tick();
            end
        end
        adc_valid = 1'b1;
        adc_data  = DW'(999);
        start     = 1'b1;
        tick();
        start = 1'b0;
        wait_valid(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL gaps_wait_valid: got valid=%b, want 1 within 10 cycles", sink_valid);
            adc_valid = 1'b0;
            return;
        end
        for (int b = 0; b < N; b++) begin
            got = int'($signed(sink_real));
            checks++;
            if (sink_valid !== 1'b1 || got != exp_beat(10 * (b + 1), 360) || sink_sop !== (b == 0)
                || sink_eop !== (b == N - 1)) begin
                errors++;
                $display("FAIL gaps_beat%0d: got v=%b real=%0d sop=%b eop=%b, want v=1 real=%0d sop=%b eop=%b",
                         b, sink_valid, got, sink_sop, sink_eop, exp_beat(10 * (b + 1), 360), b == 0, b == N - 1);
            end
            start = (b == 3);
            tick();
        end
        start = 1'b0;
        adc_valid = 1'b0;
        checks++;
        if ({frame_done, busy} !== 2'b10) begin
            errors++;
            $display("FAIL gaps_done: got done=%b busy=%b, want 1 0", frame_done, busy);
        end
        tick();
        checks++;
        if ({busy, sink_valid} !== 2'b00) begin
            errors++;
            $display("FAIL gaps_idle_after: got busy=%b valid=%b, want 0 0", busy, sink_valid);
        end
    endtask

    task automatic test_reset_mid_send();
        bit ok;
        int got;
        sink_ready = 1'b1;
        start_pulse();
        fill_consecutive(1);
        wait_valid(ok);
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({sink_valid, sink_sop, sink_eop, sink_real, sink_imag, busy, frame_done} !== '0) begin
            errors++;
            $display("FAIL rst_mid_send: got v=%b sop=%b eop=%b real=%0h busy=%b done=%b, want all 0",
                     sink_valid, sink_sop, sink_eop, sink_real, busy, frame_done);
        end
        start_pulse();
        fill_consecutive(21);
        wait_valid(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL rst_refill_wait_valid: got valid=%b, want 1 within 10 cycles", sink_valid);
            return;
        end
        for (int b = 0; b < N; b++) begin
            got = int'($signed(sink_real));
            checks++;
            if (sink_valid !== 1'b1 || got != exp_beat(21 + b, 196) || sink_sop !== (b == 0)
                || sink_eop !== (b == N - 1)) begin
                errors++;
                $display("FAIL rst_refill_beat%0d: got v=%b real=%0d sop=%b eop=%b, want v=1 real=%0d sop=%b eop=%b",
                         b, sink_valid, got, sink_sop, sink_eop, exp_beat(21 + b, 196), b == 0, b == N - 1);
            end
            tick();
        end
        checks++;
        if (frame_done !== 1'b1) begin
            errors++;
            $display("FAIL rst_refill_done: got %b, want 1", frame_done);
        end
        tick();
    endtask

`ifdef FFT_FEEDER_DC_REMOVE_EN
    task automatic test_dc_remove();
        bit ok;
        int got;
        int want;
        sink_ready = 1'b1;
        for (int f = 0; f < 2; f++) begin
            start_pulse();
            for (int i = 0; i < N; i++) begin
                adc_valid = 1'b1;
                adc_data  = (f == 0) ? 16'd100 : ((i % 2 == 0) ? 16'h7fff : 16'h8000);
                tick();
            end
            adc_valid = 1'b0;
            wait_valid(ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL dc_wait_valid frame %0d: got valid=%b, want 1", f, sink_valid);
                return;
            end
            for (int b = 0; b < N; b++) begin
                want = (f == 0) ? 0 : ((b % 2 == 0) ? 32767 : -32767);
                got  = int'($signed(sink_real));
                checks++;
                if (sink_valid !== 1'b1 || got != want) begin
                    errors++;
                    $display("FAIL dc_frame%0d_beat%0d: got v=%b real=%0d, want v=1 real=%0d", f, b, sink_valid, got, want);
                end
                tick();
            end
            tick();
        end
    endtask
`endif

    initial begin
        rst = 1'b1; start = 1'b0; adc_valid = 1'b0; adc_data = '0; sink_ready = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_gaps_drops();
        test_reset_mid_send();
`ifdef FFT_FEEDER_DC_REMOVE_EN
        test_dc_remove();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
